// File: rtl/simon_pkg.sv
// Shared colour encodings, index helpers and FSM state type for the Simon autoplayer.
package simon_pkg;

    localparam logic [3:0] RED    = 4'b0001;
    localparam logic [3:0] GREEN  = 4'b0010;
    localparam logic [3:0] BLUE   = 4'b0100;
    localparam logic [3:0] YELLOW = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LISTEN,
        ST_PRESS,
        ST_GAP
    } state_e;

    function automatic logic [1:0] onehot2idx(input logic [3:0] c);
        logic [1:0] idx;
        case (c)
            GREEN:   idx = 2'd1;
            BLUE:    idx = 2'd2;
            YELLOW:  idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] idx2onehot(input logic [1:0] idx);
        return RED << idx;
    endfunction

    function automatic logic is_onehot(input logic [3:0] c);
        return (c != 4'd0) && ((c & (c - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/simon_seq_mem.sv
// Colour sequence store: DEPTH x 2-bit registers, synchronous write, combinational read.
module simon_seq_mem #(
    parameter int unsigned DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [1:0]               wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [1:0]               rdata_o
);

    logic [1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/simon_autoplayer.sv
// Simon self-player: records the core's colour display, then replays it as timed button presses.
module simon_autoplayer
    import simon_pkg::*;
#(
    parameter int unsigned DEPTH        = 32,
    parameter int unsigned IDLE_CYCLES  = 50,
    parameter int unsigned PRESS_CYCLES = 10,
    parameter int unsigned GAP_CYCLES   = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [3:0]                 colour,
    output logic [3:0]                 button,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] seq_len,
    output logic                       overflow,
    output logic                       bad_colour,
    output logic                       done
);

    localparam int unsigned SLW   = $clog2(DEPTH + 1);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned ICW   = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam int unsigned PCMAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
    localparam int unsigned PCW   = (PCMAX > 1) ? $clog2(PCMAX) : 1;

    state_e         state_q, state_d;
    logic [3:0]     colour_q, colour_d;
    logic [3:0]     button_q, button_d;
    logic [SLW-1:0] seq_len_q, seq_len_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ICW-1:0] idle_cnt_q, idle_cnt_d;
    logic [PCW-1:0] cnt_q, cnt_d;
    logic           overflow_q, overflow_d;
    logic           bad_q, bad_d;
    logic           done_q, done_d;

    logic           we;
    logic [AW-1:0]  raddr;
    logic [1:0]     rdata;
    logic           event_seen;

    simon_seq_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (seq_len_q[AW-1:0]),
        .wdata_i (onehot2idx(colour)),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    // GAP looks one entry ahead so the next press is loaded straight into the button flop.
    assign raddr      = (state_q == ST_GAP) ? rd_ptr_q + 1'b1 : rd_ptr_q;
    assign event_seen = (colour != 4'd0) && (colour != colour_q);

    always_comb begin
        state_d    = state_q;
        colour_d   = colour;
        button_d   = button_q;
        seq_len_d  = seq_len_q;
        rd_ptr_d   = rd_ptr_q;
        idle_cnt_d = '0;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        bad_d      = bad_q;
        done_d     = 1'b0;
        we         = 1'b0;

        if (!enable) begin
            state_d  = ST_IDLE;
            button_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_LISTEN;
                    seq_len_d = '0;
                end
                ST_LISTEN: begin
                    if (colour == 4'd0) begin
                        idle_cnt_d = (idle_cnt_q == ICW'(IDLE_CYCLES - 1)) ? idle_cnt_q
                                                                             : idle_cnt_q + 1'b1;
                    end
                    if (event_seen) begin
                        if (!is_onehot(colour)) begin
                            bad_d = 1'b1;
                        end else if (seq_len_q == SLW'(DEPTH)) begin
                            overflow_d = 1'b1;
                        end else begin
                            we        = 1'b1;
                            seq_len_d = seq_len_q + 1'b1;
                        end
                    end
                    if ((colour == 4'd0) && (idle_cnt_q == ICW'(IDLE_CYCLES - 1)) &&
                        (seq_len_q != '0)) begin
                        state_d    = ST_PRESS;
                        idle_cnt_d = '0;
                        cnt_d      = '0;
                        rd_ptr_d   = '0;
                        button_d   = idx2onehot(rdata);
                    end
                end
                ST_PRESS: begin
                    if (cnt_q == PCW'(PRESS_CYCLES - 1)) begin
                        state_d  = ST_GAP;
                        button_d = '0;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == PCW'(GAP_CYCLES - 1)) begin
                        cnt_d = '0;
                        if (SLW'(rd_ptr_q) == seq_len_q - 1'b1) begin
                            state_d   = ST_LISTEN;
                            done_d    = 1'b1;
                            seq_len_d = '0;
                            rd_ptr_d  = '0;
                        end else begin
                            state_d  = ST_PRESS;
                            rd_ptr_d = rd_ptr_q + 1'b1;
                            button_d = idx2onehot(rdata);
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            colour_q   <= '0;
            button_q   <= '0;
            seq_len_q  <= '0;
            rd_ptr_q   <= '0;
            idle_cnt_q <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            bad_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            colour_q   <= colour_d;
            button_q   <= button_d;
            seq_len_q  <= seq_len_d;
            rd_ptr_q   <= rd_ptr_d;
            idle_cnt_q <= idle_cnt_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
            bad_q      <= bad_d;
            done_q     <= done_d;
        end
    end

    assign button     = button_q;
    assign busy       = (state_q == ST_PRESS) || (state_q == ST_GAP);
    assign seq_len    = seq_len_q;
    assign overflow   = overflow_q;
    assign bad_colour = bad_q;
    assign done       = done_q;

endmodule

// File: tb/tb_simon_autoplayer.sv
// Directed bench for simon_autoplayer: capture, replay timing, stickies and abort.
module tb_simon_autoplayer;
    import simon_pkg::*;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned IDLE  = 50;
    localparam int unsigned PRESS = 10;
    localparam int unsigned GAP   = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] colour;
    logic [3:0] button;
    logic       busy;
    logic [5:0] seq_len;
    logic       overflow;
    logic       bad_colour;
    logic       done;

    int tests  = 0;
    int errors = 0;

    logic [3:0] exp_seq [DEPTH];

    simon_autoplayer #(
        .DEPTH        (DEPTH),
        .IDLE_CYCLES  (IDLE),
        .PRESS_CYCLES (PRESS),
        .GAP_CYCLES   (GAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .colour     (colour),
        .button     (button),
        .busy       (busy),
        .seq_len    (seq_len),
        .overflow   (overflow),
        .bad_colour (bad_colour),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive dark colour and confirm replay starts after exactly IDLE dark cycles.
    task automatic dark_then_start(input int exp_len);
        colour = 4'd0;
        cyc(IDLE - 1);
        chk("pre_start_busy", {31'd0, busy}, 32'd0);
        chk("pre_start_len", {26'd0, seq_len}, exp_len);
        cyc(1);
        chk("start_busy", {31'd0, busy}, 32'd1);
    endtask

    // Expects to be sitting in the first PRESS cycle of a replay of n entries.
    task automatic replay(input int n);
        for (int e = 0; e < n; e++) begin
            for (int p = 0; p < int'(PRESS); p++) begin
                chk("press_btn", {28'd0, button}, {28'd0, exp_seq[e]});
                chk("press_busy", {31'd0, busy}, 32'd1);
                cyc(1);
            end
            for (int g = 0; g < int'(GAP); g++) begin
                chk("gap_btn", {28'd0, button}, 32'd0);
                chk("gap_done", {31'd0, done}, 32'd0);
                cyc(1);
            end
        end
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_len", {26'd0, seq_len}, 32'd0);
        chk("done_busy", {31'd0, busy}, 32'd0);
        cyc(1);
        chk("done_clear", {31'd0, done}, 32'd0);
    endtask

    initial begin
        // 1: reset with a colour present
        reset = 1'b0; enable = 1'b0; colour = 4'b0100;
        cyc(3);
        chk("rst_btn", {28'd0, button}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_len", {26'd0, seq_len}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_bad", {31'd0, bad_colour}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b1; colour = 4'd0;
        cyc(1);
        chk("idle_len", {26'd0, seq_len}, 32'd0);

        // 2: two colours separated by darkness
        enable = 1'b1;
        cyc(1);
        colour = 4'b0001; cyc(5);
        chk("t2_len1", {26'd0, seq_len}, 32'd1);
        colour = 4'b0000; cyc(5);
        colour = 4'b1000; cyc(5);
        chk("t2_len2", {26'd0, seq_len}, 32'd2);
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b1000;
        dark_then_start(2);
        replay(2);

        // 3: direct change between two colours
        colour = 4'b0010; cyc(5);
        colour = 4'b0100; cyc(5);
        chk("t3_len", {26'd0, seq_len}, 32'd2);
        exp_seq[0] = 4'b0010; exp_seq[1] = 4'b0100;
        dark_then_start(2);
        replay(2);

        // 4: multi-hot colour, then a dark period with nothing stored
        colour = 4'b0011; cyc(5);
        chk("t4_bad", {31'd0, bad_colour}, 32'd1);
        chk("t4_len", {26'd0, seq_len}, 32'd0);
        colour = 4'd0; cyc(IDLE + 10);
        chk("t4_no_replay", {31'd0, busy}, 32'd0);
        chk("t4_bad_sticky", {31'd0, bad_colour}, 32'd1);

        // 5: DEPTH+1 events, one per cycle
        for (int i = 0; i < int'(DEPTH); i++) begin
            colour = idx2onehot(2'(i));
            exp_seq[i] = colour;
            cyc(1);
        end
        chk("t5_full_len", {26'd0, seq_len}, DEPTH);
        chk("t5_no_ovf_yet", {31'd0, overflow}, 32'd0);
        colour = 4'b0010; cyc(1);
        chk("t5_ovf", {31'd0, overflow}, 32'd1);
        chk("t5_len_held", {26'd0, seq_len}, DEPTH);
        dark_then_start(DEPTH);
        replay(DEPTH);
        chk("t5_bad_kept", {31'd0, bad_colour}, 32'd1);

        // 6: enable drop during the second press
        colour = 4'b0100; cyc(3);
        colour = 4'b0010; cyc(3);
        dark_then_start(2);
        cyc(PRESS + GAP);
        chk("t6_press2", {28'd0, button}, 32'h2);
        cyc(3);
        enable = 1'b0;
        cyc(1);
        chk("t6_abort_btn", {28'd0, button}, 32'd0);
        chk("t6_abort_busy", {31'd0, busy}, 32'd0);
        chk("t6_ovf_kept", {31'd0, overflow}, 32'd1);
        cyc(2);
        chk("t6_idle_btn", {28'd0, button}, 32'd0);
        enable = 1'b1;
        cyc(1);
        chk("t6_len_clear", {26'd0, seq_len}, 32'd0);
        colour = 4'b1000; cyc(3);
        exp_seq[0] = 4'b1000;
        dark_then_start(1);
        replay(1);

        // Stickies clear only on reset
        reset = 1'b0; cyc(1);
        chk("end_ovf", {31'd0, overflow}, 32'd0);
        chk("end_bad", {31'd0, bad_colour}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
